// File: rtl/pmem_line_responder_pkg.sv
// Shared types and constants for the physical-memory line responder.
// Optional latency jitter is enabled by defining PMEM_JITTER_EN.
package pmem_line_responder_pkg;

  localparam int unsigned PMEM_OFFSET_BITS = 5;
  localparam logic [7:0]  PMEM_LFSR_SEED   = 8'hA5;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } pmem_state_t;

  // Fibonacci LFSR, taps 8,6,5,4 (bit 7 is tap 8).
  function automatic logic [7:0] pmem_lfsr_step(logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/pmem_line_responder_if.sv
// Cache-to-physical-memory line interface; master is the cache side, slave the memory side.
interface pmem_line_responder_if #(
  parameter int unsigned LINE_BITS = 256
);
  logic [31:0]          pmem_address;
  logic                 pmem_read;
  logic                 pmem_write;
  logic [LINE_BITS-1:0] pmem_wdata;
  logic [LINE_BITS-1:0] pmem_rdata;
  logic                 pmem_resp;
  logic                 proto_err;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp, proto_err
  );

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp, proto_err
  );
endinterface

// File: rtl/pmem_line_responder_array.sv
// Line storage: synchronous write, combinational read on a single shared address; no reset.
module pmem_line_responder_array #(
  parameter int unsigned LINE_BITS  = 256,
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] addr_i,
  input  logic [LINE_BITS-1:0]  wdata_i,
  output logic [LINE_BITS-1:0]  rdata_o
);

  logic [LINE_BITS-1:0] mem_q [2**INDEX_BITS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // The top registers this value on the edge that enters the response state.
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency physical-memory line responder: one read or write in flight at a time.
// Define PMEM_JITTER_EN to add 0..7 LFSR-driven extra busy cycles per request.
module pmem_line_responder
  import pmem_line_responder_pkg::*;
#(
  parameter int unsigned LINE_BITS  = 256,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned LATENCY    = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  pmem_line_responder_if.slave        pmem_io
);

  if (LATENCY < 2 || LATENCY > 255) begin : g_bad_latency
    $error("pmem_line_responder: LATENCY must be within 2..255");
  end

`ifdef PMEM_JITTER_EN
  localparam int unsigned CntW = 9;
`else
  localparam int unsigned CntW = 8;
`endif

  pmem_state_t           state_q;
  logic [CntW-1:0]       cnt_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [LINE_BITS-1:0]  wdata_q;
  logic                  resp_q;
  logic [LINE_BITS-1:0]  rdata_q;
  logic                  err_q;

  logic                  req;
  logic                  accept;
  logic                  done;
  logic                  arr_we;
  logic [LINE_BITS-1:0]  arr_rdata;
  logic [CntW-1:0]       cnt_load;
  logic [INDEX_BITS-1:0] accept_idx;
  logic                  unused_addr;

  assign req        = pmem_io.pmem_read | pmem_io.pmem_write;
  assign accept     = (state_q == StIdle) && req;
  assign done       = (state_q == StBusy) && (cnt_q == '0);
  assign arr_we     = done && wr_q;
  assign accept_idx = pmem_io.pmem_address[PMEM_OFFSET_BITS +: INDEX_BITS];
  assign unused_addr = ^{pmem_io.pmem_address[31:PMEM_OFFSET_BITS+INDEX_BITS],
                         pmem_io.pmem_address[PMEM_OFFSET_BITS-1:0]};

`ifdef PMEM_JITTER_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= PMEM_LFSR_SEED;
    end else if (accept) begin
      lfsr_q <= pmem_lfsr_step(lfsr_q);
    end
  end

  assign cnt_load = CntW'(LATENCY - 1) + CntW'(lfsr_q[2:0]);
`else
  assign cnt_load = CntW'(LATENCY - 1);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            idx_q   <= accept_idx;
            // Simultaneous read and write is a protocol error: no array access at all.
            rd_q    <= pmem_io.pmem_read & ~pmem_io.pmem_write;
            wr_q    <= pmem_io.pmem_write & ~pmem_io.pmem_read;
            wdata_q <= pmem_io.pmem_wdata;
            cnt_q   <= cnt_load;
            if (pmem_io.pmem_read && pmem_io.pmem_write) begin
              err_q <= 1'b1;
            end
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
            resp_q  <= 1'b1;
            if (rd_q) begin
              rdata_q <= arr_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: begin
          resp_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pmem_line_responder_array #(
    .LINE_BITS  (LINE_BITS),
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign pmem_io.pmem_rdata = rdata_q;
  assign pmem_io.pmem_resp  = resp_q;
  assign pmem_io.proto_err  = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed scoreboard bench for pmem_line_responder; covers PMEM_JITTER_EN when defined.
module tb_pmem_line_responder;
  import pmem_line_responder_pkg::*;

  localparam int unsigned Lat = 10;

  typedef struct {
    logic [255:0] rdata;
    int           lat;
    logic         err;
  } exp_t;

  logic clk;
  logic rst_ni;
  int   n_assert;
  int   n_fail;

  exp_t         sb_q[$];
  logic [255:0] model_mem [int];
  logic [255:0] model_rdata;
  logic         model_err;
  logic [7:0]   model_lfsr;

  pmem_line_responder_if #(.LINE_BITS(256)) bus_if ();

  pmem_line_responder #(
    .LINE_BITS  (256),
    .INDEX_BITS (6),
    .LATENCY    (Lat)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .pmem_io (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_lat();
    int l;
    l = Lat;
`ifdef PMEM_JITTER_EN
    l = Lat + int'(model_lfsr[2:0]);
    model_lfsr = pmem_lfsr_step(model_lfsr);
`endif
    return l;
  endfunction

  task automatic model_reset();
    model_rdata = '0;
    model_err   = 1'b0;
    model_lfsr  = PMEM_LFSR_SEED;
  endtask

  // Drive one request, push its expectation, wait (bounded) for resp, compare.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [255:0] wd, input string tag);
    exp_t e;
    int   idx;
    int   lat;
    bit   seen;
    idx = int'(addr[10:5]);
    @(negedge clk);
    bus_if.pmem_address = addr;
    bus_if.pmem_read    = rd;
    bus_if.pmem_write   = wr;
    bus_if.pmem_wdata   = wd;
    e.lat = next_lat();
    if (rd && wr) model_err = 1'b1;
    else if (rd) model_rdata = model_mem[idx];
    else model_mem[idx] = wd;
    e.rdata = model_rdata;
    e.err   = model_err;
    sb_q.push_back(e);
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus_if.pmem_resp) seen = 1'b1;
    end
    chk({tag, "_resp_seen"}, 256'(seen), 256'(1));
    e = sb_q.pop_front();
    chk({tag, "_latency"}, 256'(lat), 256'(e.lat));
`ifdef PMEM_JITTER_EN
    chk({tag, "_lat_range"}, 256'(lat >= 10 && lat <= 17), 256'(1));
`endif
    chk({tag, "_rdata"}, bus_if.pmem_rdata, e.rdata);
    chk({tag, "_proto_err"}, 256'(bus_if.proto_err), 256'(e.err));
    @(negedge clk);
    bus_if.pmem_read  = 1'b0;
    bus_if.pmem_write = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_resp_one_cycle"}, 256'(bus_if.pmem_resp), 256'(0));
  endtask

  initial begin
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] c;
    a = {8{32'hA5A5_0001}};
    b = {8{32'hB6B6_0002}};
    c = {8{32'hC3C3_0003}};
    n_assert = 0;
    n_fail   = 0;
    model_reset();
    rst_ni              = 1'b0;
    bus_if.pmem_address = '0;
    bus_if.pmem_read    = 1'b0;
    bus_if.pmem_write   = 1'b0;
    bus_if.pmem_wdata   = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle_resp", 256'(bus_if.pmem_resp), 256'(0));
    end
    chk("idle_rdata", bus_if.pmem_rdata, 256'(0));
    chk("idle_proto_err", 256'(bus_if.proto_err), 256'(0));

    // Basic write then read
    do_op(1'b0, 1'b1, 32'h4000_8000, 256'h1234, "wr_1234");
    do_op(1'b1, 1'b0, 32'h4000_8000, '0, "rd_1234");

    // Two lines, offset ignored, high bits alias
    do_op(1'b0, 1'b1, 32'h4000_8000, a, "wr_a");
    do_op(1'b0, 1'b1, 32'h4000_8020, b, "wr_b");
    do_op(1'b1, 1'b0, 32'h4000_8000, '0, "rd_a");
    do_op(1'b1, 1'b0, 32'h4000_8020, '0, "rd_b");
    do_op(1'b1, 1'b0, 32'h4000_8008, '0, "rd_offset");
    do_op(1'b1, 1'b0, 32'h4000_8800, '0, "rd_alias");

    // Read and write together: sticky error, no array access
    do_op(1'b1, 1'b1, 32'h4000_8000, c, "rw_both");
    do_op(1'b1, 1'b0, 32'h4000_8000, '0, "rd_after_err");

    // Reset during BUSY discards a pending write
    @(negedge clk);
    bus_if.pmem_address = 32'h4000_8000;
    bus_if.pmem_write   = 1'b1;
    bus_if.pmem_wdata   = 256'hFFFF;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("rst_resp", 256'(bus_if.pmem_resp), 256'(0));
    chk("rst_rdata", bus_if.pmem_rdata, 256'(0));
    chk("rst_proto_err", 256'(bus_if.proto_err), 256'(0));
    @(negedge clk);
    bus_if.pmem_write = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("rst_no_resp", 256'(bus_if.pmem_resp), 256'(0));
    end
    do_op(1'b1, 1'b0, 32'h4000_8000, '0, "rd_after_rst");

`ifdef PMEM_JITTER_EN
    // Jittered latency sequence restarts from the seed after reset
    @(negedge clk);
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 32; i++) begin
      do_op(1'b1, 1'b0, 32'h4000_8020, '0, "jit_rd");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
